// File: rtl/bank_queue_ctrl_pkg.sv
// Shared types and constants for the bank queue occupancy controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bank_queue_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        HELD  = 2'd2
    } deb_state_t;

    localparam int PCOUNT_W = 4;
    localparam int TCOUNT_W = 2;
    localparam logic [TCOUNT_W-1:0] TCOUNT_RST = 2'b01;

endpackage

// File: rtl/bank_queue_ctrl_debounce.sv
// Beam sensor synchronizer plus debounce FSM; emits one event per qualified blockage.
// Latency: event_vld pulses 3 clocks after the beam release reaches the sensor pin.
// Backpressure: none; events are single-cycle pulses and are never stalled.
module sensor_debounce
    import bank_queue_ctrl_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sensor,
    output logic event_vld
);

    localparam logic [3:0] RUN_DONE = 4'(DEBOUNCE);

    logic       sync_q1;
    logic       sync_q2;
    logic [3:0] run_cnt;
    deb_state_t state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1   <= 1'b0;
            sync_q2   <= 1'b0;
            run_cnt   <= 4'd0;
            state     <= IDLE;
            event_vld <= 1'b0;
        end else begin
            sync_q1   <= sensor;
            sync_q2   <= sync_q1;
            event_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (sync_q2) begin
                        // The cycle that arms the FSM is the first of the run.
                        state   <= ARMED;
                        run_cnt <= 4'd1;
                    end
                end
                ARMED: begin
                    if (!sync_q2) begin
                        state   <= IDLE;
                        run_cnt <= 4'd0;
                    end else begin
                        run_cnt <= run_cnt + 4'd1;
                        if (run_cnt + 4'd1 >= RUN_DONE) begin
                            state <= HELD;
                        end
                    end
                end
                HELD: begin
                    // Count on release so a customer standing in the beam counts once.
                    if (!sync_q2) begin
                        state     <= IDLE;
                        run_cnt   <= 4'd0;
                        event_vld <= 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    run_cnt <= 4'd0;
                end
            endcase
        end
    end

endmodule

// File: rtl/bank_queue_ctrl.sv
// Queue occupancy counter fed by debounced entry/exit beams, plus teller count register.
// Latency: pcount moves 4 clocks after a qualified beam release at the sensor pin.
// Backpressure: none; entries while full are dropped and flagged on entry_drop.
module bank_queue_ctrl
    import bank_queue_ctrl_pkg::*;
#(
    parameter int DEBOUNCE = 4,
    parameter int MAXP     = 7
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                back_sensor,
    input  logic                front_sensor,
    input  logic [TCOUNT_W-1:0] tcount_in,
    output logic [PCOUNT_W-1:0] pcount,
    output logic [TCOUNT_W-1:0] tcount,
    output logic                full,
    output logic                empty,
    output logic                entry_drop
);

    localparam logic [PCOUNT_W-1:0] PMAX = PCOUNT_W'(MAXP);

    logic entry_vld;
    logic exit_vld;

    sensor_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_entry_deb (
        .clk       (clk),
        .rst_n     (rst_n),
        .sensor    (back_sensor),
        .event_vld (entry_vld)
    );

    sensor_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_exit_deb (
        .clk       (clk),
        .rst_n     (rst_n),
        .sensor    (front_sensor),
        .event_vld (exit_vld)
    );

    assign full       = (pcount == PMAX);
    assign empty      = (pcount == '0);
    assign entry_drop = entry_vld & ~exit_vld & full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcount <= '0;
            tcount <= TCOUNT_RST;
        end else begin
            // Simultaneous entry and exit cancel, including at both saturation points.
            if (entry_vld && !exit_vld && !full) begin
                pcount <= pcount + PCOUNT_W'(1);
            end else if (exit_vld && !entry_vld && !empty) begin
                pcount <= pcount - PCOUNT_W'(1);
            end
            if (tcount_in != '0) begin
                tcount <= tcount_in;
            end
        end
    end

endmodule
